// File: rtl/pong_pkg.sv
// Shared types and constants for the pong paddle timer slice.
// Optional digital paddle control is enabled with PADDLE_DIGITAL_EN.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        TIMING = 2'd2,
        DONE   = 2'd3
    } pad_state_t;

    localparam logic [7:0] PAD_RESET_POS = 8'h80;
    localparam int         PAD_CNT_W     = 9;

    // Move a position by one step toward top (up) or bottom (dn), clamped to 0..255.
    function automatic logic [7:0] pad_sat_step(
        input logic [7:0] pos,
        input logic [7:0] step,
        input logic       up,
        input logic       dn
    );
        logic [8:0] sum;
        logic [7:0] res;
        sum = {1'b0, pos} + {1'b0, step};
        if (up && !dn) begin
            if (pos < step) begin
                res = 8'h00;
            end else begin
                res = pos - step;
            end
        end else if (dn && !up) begin
            if (sum[8]) begin
                res = 8'hFF;
            end else begin
                res = sum[7:0];
            end
        end else begin
            res = pos;
        end
        return res;
    endfunction

endpackage

// File: rtl/paddle_timer_if.sv
// Sync/position inputs and one-shot outputs of the paddle timer.
// Digital control lines exist only with PADDLE_DIGITAL_EN.
interface paddle_timer_if;

    logic       hsync;
    logic       vsync;
    logic [7:0] vpos_in;
`ifdef PADDLE_DIGITAL_EN
    logic       dig_up;
    logic       dig_dn;
    logic       dig_sel;
`endif
    logic       pad_q;
    logic       pad_done;
    logic [7:0] vpos_lat;

`ifdef PADDLE_DIGITAL_EN
    modport master (
        output hsync, vsync, vpos_in, dig_up, dig_dn, dig_sel,
        input  pad_q, pad_done, vpos_lat
    );
    modport slave (
        input  hsync, vsync, vpos_in, dig_up, dig_dn, dig_sel,
        output pad_q, pad_done, vpos_lat
    );
`else
    modport master (
        output hsync, vsync, vpos_in,
        input  pad_q, pad_done, vpos_lat
    );
    modport slave (
        input  hsync, vsync, vpos_in,
        output pad_q, pad_done, vpos_lat
    );
`endif

endinterface

// File: rtl/pad_pos_integrator.sv
// Digital paddle position: saturating per-frame step driven by up/down buttons.
// Only instantiated when PADDLE_DIGITAL_EN is defined.
module pad_pos_integrator
    import pong_pkg::*;
#(
    parameter int DIG_STEP = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       step_en,
    input  logic       dig_up,
    input  logic       dig_dn,
    output logic [7:0] pos_next
);

    localparam logic [7:0] STEP_W = 8'(DIG_STEP);

    logic [7:0] pos_dig_r;

    // Next position; the frame latch takes this value on the same edge as the step.
    always_comb begin
        pos_next = pad_sat_step(pos_dig_r, STEP_W, dig_up, dig_dn);
    end

    // Position register, advanced once per frame.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pos_dig_r <= PAD_RESET_POS;
        end else if (step_en) begin
            pos_dig_r <= pos_next;
        end else begin
            pos_dig_r <= pos_dig_r;
        end
    end

endmodule

// File: rtl/paddle_timer.sv
// Per-frame paddle one-shot: pulse width in hsync lines equals the latched position.
// Build with PADDLE_DIGITAL_EN to add the digital up/down position source.
module paddle_timer
    import pong_pkg::*;
#(
    parameter int LINE_OFFSET = 16,
    parameter int DIG_STEP    = 4
) (
    input  logic           clk_sys,
    input  logic           reset,
    paddle_timer_if.slave  pad_if
);

    localparam logic [PAD_CNT_W-1:0] OFFSET_W = 9'(LINE_OFFSET);

    if (LINE_OFFSET < 0 || LINE_OFFSET > 255) begin : g_bad_offset
        $error("paddle_timer: LINE_OFFSET out of range");
    end
    if (DIG_STEP < 1 || DIG_STEP > 64) begin : g_bad_step
        $error("paddle_timer: DIG_STEP out of range");
    end

    pad_state_t           state_r;
    logic [PAD_CNT_W-1:0] cnt_r;
    logic [PAD_CNT_W-1:0] cnt_inc_s;
    logic                 hs_prev_r;
    logic                 vs_prev_r;
    logic                 hs_rise_s;
    logic                 vs_rise_s;
    logic                 pad_q_r;
    logic                 pad_done_r;
    logic [7:0]           vpos_lat_r;
    logic [7:0]           pos_sel_s;

    // Edge detect against last cycle's sync levels.
    always_comb begin
        hs_rise_s = pad_if.hsync & ~hs_prev_r;
        vs_rise_s = pad_if.vsync & ~vs_prev_r;
        cnt_inc_s = cnt_r + 9'd1;
    end

`ifdef PADDLE_DIGITAL_EN
    logic [7:0] pos_next_s;

    pad_pos_integrator #(
        .DIG_STEP (DIG_STEP)
    ) u_pos_int (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .step_en  (vs_rise_s),
        .dig_up   (pad_if.dig_up),
        .dig_dn   (pad_if.dig_dn),
        .pos_next (pos_next_s)
    );

    // Frame position source: stepped digital value or the analog input.
    always_comb begin
        if (pad_if.dig_sel) begin
            pos_sel_s = pos_next_s;
        end else begin
            pos_sel_s = pad_if.vpos_in;
        end
    end
`else
    // Frame position source: analog input only.
    always_comb begin
        pos_sel_s = pad_if.vpos_in;
    end
`endif

    // One-shot FSM; a vsync rise restarts the frame from any state and hides a coincident hsync.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= 9'd0;
            hs_prev_r  <= 1'b0;
            vs_prev_r  <= 1'b0;
            pad_q_r    <= 1'b0;
            pad_done_r <= 1'b0;
            vpos_lat_r <= PAD_RESET_POS;
        end else begin
            hs_prev_r  <= pad_if.hsync;
            vs_prev_r  <= pad_if.vsync;
            pad_done_r <= 1'b0;
            if (vs_rise_s) begin
                vpos_lat_r <= pos_sel_s;
                cnt_r      <= 9'd0;
                if (LINE_OFFSET == 0) begin
                    if (pos_sel_s == 8'd0) begin
                        state_r    <= DONE;
                        pad_q_r    <= 1'b0;
                        pad_done_r <= 1'b1;
                    end else begin
                        state_r <= TIMING;
                        pad_q_r <= 1'b1;
                    end
                end else begin
                    state_r <= WAIT;
                    pad_q_r <= 1'b0;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        pad_q_r <= 1'b0;
                    end
                    WAIT: begin
                        if (hs_rise_s) begin
                            if (cnt_inc_s == OFFSET_W) begin
                                cnt_r <= 9'd0;
                                if (vpos_lat_r == 8'd0) begin
                                    state_r    <= DONE;
                                    pad_done_r <= 1'b1;
                                end else begin
                                    state_r <= TIMING;
                                    pad_q_r <= 1'b1;
                                end
                            end else begin
                                cnt_r <= cnt_inc_s;
                            end
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end
                    TIMING: begin
                        if (hs_rise_s) begin
                            if (cnt_inc_s == {1'b0, vpos_lat_r}) begin
                                state_r    <= DONE;
                                cnt_r      <= 9'd0;
                                pad_q_r    <= 1'b0;
                                pad_done_r <= 1'b1;
                            end else begin
                                cnt_r <= cnt_inc_s;
                            end
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        pad_q_r <= 1'b0;
                        cnt_r   <= 9'd0;
                    end
                endcase
            end
        end
    end

    assign pad_if.pad_q    = pad_q_r;
    assign pad_if.pad_done = pad_done_r;
    assign pad_if.vpos_lat = vpos_lat_r;

endmodule

// File: tb/tb_paddle_timer.sv
// Directed bench for paddle_timer: offset-16 instance (A) and offset-0 instance (B).
module tb_paddle_timer;

    logic       clk_sys;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic [7:0] vpos_a;
    logic [7:0] vpos_b;
`ifdef PADDLE_DIGITAL_EN
    logic       dig_up;
    logic       dig_dn;
    logic       dig_sel;
`endif

    int n_checks;
    int n_fail;
    int hs_count;
    int qa_rises, qa_rise_at, qa_fall_at, qa_cycles, qa_done;
    int qb_rises, qb_rise_at, qb_fall_at, qb_cycles, qb_done;
    logic qa_prev, qb_prev;

    paddle_timer_if ifa ();
    paddle_timer_if ifb ();

    assign ifa.hsync   = hsync;
    assign ifa.vsync   = vsync;
    assign ifa.vpos_in = vpos_a;
    assign ifb.hsync   = hsync;
    assign ifb.vsync   = vsync;
    assign ifb.vpos_in = vpos_b;
`ifdef PADDLE_DIGITAL_EN
    assign ifa.dig_up  = dig_up;
    assign ifa.dig_dn  = dig_dn;
    assign ifa.dig_sel = dig_sel;
    assign ifb.dig_up  = dig_up;
    assign ifb.dig_dn  = dig_dn;
    assign ifb.dig_sel = dig_sel;
`endif

    paddle_timer #(.LINE_OFFSET(16), .DIG_STEP(4)) u_dut_a (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pad_if  (ifa)
    );

    paddle_timer #(.LINE_OFFSET(0), .DIG_STEP(4)) u_dut_b (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pad_if  (ifb)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, then sample both instances away from the edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (ifa.pad_q && !qa_prev) begin qa_rises++; qa_rise_at = hs_count; end
        if (!ifa.pad_q && qa_prev) qa_fall_at = hs_count;
        qa_cycles += int'(ifa.pad_q);
        qa_done   += int'(ifa.pad_done);
        qa_prev    = ifa.pad_q;
        if (ifb.pad_q && !qb_prev) begin qb_rises++; qb_rise_at = hs_count; end
        if (!ifb.pad_q && qb_prev) qb_fall_at = hs_count;
        qb_cycles += int'(ifb.pad_q);
        qb_done   += int'(ifb.pad_done);
        qb_prev    = ifb.pad_q;
    endtask

    task automatic clear_mon();
        hs_count = 0;
        qa_rises = 0; qa_rise_at = -1; qa_fall_at = -1; qa_cycles = 0; qa_done = 0;
        qb_rises = 0; qb_rise_at = -1; qb_fall_at = -1; qb_cycles = 0; qb_done = 0;
        qa_prev = ifa.pad_q;
        qb_prev = ifb.pad_q;
    endtask

    task automatic hs_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            hsync = 1'b1;
            hs_count++;
            tick();
            hsync = 1'b0;
            tick();
        end
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pos;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        hsync    = 1'b0;
        vsync    = 1'b0;
        vpos_a   = 8'd40;
        vpos_b   = 8'd255;
`ifdef PADDLE_DIGITAL_EN
        dig_up   = 1'b0;
        dig_dn   = 1'b0;
        dig_sel  = 1'b0;
`endif
        clear_mon();
        tick();
        tick();
        check("reset_pad_q",    32'(ifa.pad_q),    32'd0);
        check("reset_pad_done", 32'(ifa.pad_done), 32'd0);
        check("reset_vpos_lat", 32'(ifa.vpos_lat), 32'h80);
        reset = 1'b0;
        tick();

        // Nominal frame, with a mid-frame position change that must be ignored
        clear_mon();
        vs_pulse();
        check("nom_vpos_lat", 32'(ifa.vpos_lat), 32'd40);
        hs_pulse(20);
        vpos_a = 8'd99;
        hs_pulse(280);
        check("nom_rise_line", 32'(qa_rise_at), 32'd16);
        check("nom_fall_line", 32'(qa_fall_at), 32'd56);
        check("nom_high_clks", 32'(qa_cycles),  32'd80);
        check("nom_rises",     32'(qa_rises),   32'd1);
        check("nom_done_cnt",  32'(qa_done),    32'd1);
        check("nom_lat_hold",  32'(ifa.vpos_lat), 32'd40);

        // Zero-width window
        vpos_a = 8'd0;
        clear_mon();
        vs_pulse();
        check("zero_vpos_lat", 32'(ifa.vpos_lat), 32'd0);
        hs_pulse(15);
        check("zero_no_done_early", 32'(qa_done), 32'd0);
        hsync = 1'b1;
        hs_count++;
        tick();
        check("zero_done_pulse", 32'(ifa.pad_done), 32'd1);
        hsync = 1'b0;
        tick();
        check("zero_done_single", 32'(ifa.pad_done), 32'd0);
        hs_pulse(50);
        check("zero_no_rise",  32'(qa_rises), 32'd0);
        check("zero_done_cnt", 32'(qa_done),  32'd1);

        // Coincident hsync/vsync rise, then restart at line 20 of the pulse
        vpos_a = 8'd40;
        clear_mon();
        hsync = 1'b1;
        vsync = 1'b1;
        tick();
        hsync = 1'b0;
        vsync = 1'b0;
        tick();
        check("coin_vpos_lat", 32'(ifa.vpos_lat), 32'd40);
        hs_pulse(15);
        check("coin_not_yet", 32'(ifa.pad_q), 32'd0);
        hs_pulse(1);
        check("coin_rise", 32'(ifa.pad_q), 32'd1);
        hs_pulse(20);
        check("coin_line20_high", 32'(ifa.pad_q), 32'd1);
        vpos_a = 8'd50;
        vsync = 1'b1;
        tick();
        check("restart_pad_q",    32'(ifa.pad_q),    32'd0);
        check("restart_pad_done", 32'(ifa.pad_done), 32'd0);
        check("restart_vpos_lat", 32'(ifa.vpos_lat), 32'd50);
        vsync = 1'b0;
        tick();
        check("restart_no_done", 32'(qa_done), 32'd0);
        clear_mon();
        hs_pulse(80);
        check("restart_rise_line", 32'(qa_rise_at), 32'd16);
        check("restart_fall_line", 32'(qa_fall_at), 32'd66);
        check("restart_done_cnt",  32'(qa_done),    32'd1);

        // Reset in the middle of a pulse
        vpos_a = 8'd40;
        clear_mon();
        vs_pulse();
        hs_pulse(26);
        check("rst_pre_high", 32'(ifa.pad_q), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async_pad_q",    32'(ifa.pad_q),    32'd0);
        check("rst_async_vpos_lat", 32'(ifa.vpos_lat), 32'h80);
        check("rst_async_pad_done", 32'(ifa.pad_done), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        clear_mon();
        hs_pulse(100);
        check("rst_no_rise",  32'(qa_rises), 32'd0);
        check("rst_no_done",  32'(qa_done),  32'd0);
        check("rst_idle_lat", 32'(ifa.vpos_lat), 32'h80);

        // Offset 0 instance, full-scale width
        clear_mon();
        vsync = 1'b1;
        tick();
        check("off0_rise",     32'(ifb.pad_q),    32'd1);
        check("off0_vpos_lat", 32'(ifb.vpos_lat), 32'd255);
        vsync = 1'b0;
        tick();
        hs_pulse(254);
        check("off0_line254_high", 32'(ifb.pad_q), 32'd1);
        hs_pulse(1);
        check("off0_fall",      32'(ifb.pad_q),   32'd0);
        check("off0_fall_line", 32'(qb_fall_at),  32'd255);
        check("off0_high_clks", 32'(qb_cycles),   32'd510);
        check("off0_rises",     32'(qb_rises),    32'd1);
        check("off0_done_cnt",  32'(qb_done),     32'd1);

`ifdef PADDLE_DIGITAL_EN
        // Digital stepping with saturation at both ends
        dig_sel = 1'b1;
        dig_dn  = 1'b1;
        exp_pos = 128;
        for (int f = 0; f < 40; f++) begin
            exp_pos = (exp_pos + 4 > 255) ? 255 : exp_pos + 4;
            vs_pulse();
            check("dig_dn_lat", 32'(ifa.vpos_lat), 32'(exp_pos));
        end
        dig_dn = 1'b0;
        dig_up = 1'b1;
        for (int f = 0; f < 70; f++) begin
            exp_pos = (exp_pos < 4) ? 0 : exp_pos - 4;
            vs_pulse();
            check("dig_up_lat", 32'(ifa.vpos_lat), 32'(exp_pos));
        end
        dig_dn = 1'b1;
        for (int f = 0; f < 3; f++) begin
            vs_pulse();
            check("dig_both_hold", 32'(ifa.vpos_lat), 32'd0);
        end
        dig_up  = 1'b0;
        dig_dn  = 1'b0;
        dig_sel = 1'b0;
`else
        exp_pos = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_timer.md
# paddle_timer

Emulates the transmitter end of the original Pong paddle interface: the per-frame 555 one-shot whose pulse width encodes paddle position. Given an 8-bit paddle position, it launches a timing pulse at each vertical sync and holds it high for a number of horizontal lines equal to the position. The pulse feeds the pong core's paddle-window receiver.

- Instantiated once per player between the emu top-level joystick/paddle mapping and the pong core.

## Interface

**Parameters**

- `LINE_OFFSET`, default 16: hsync lines after the vsync rise before the pulse starts. Legal range 0..255.
- `DIG_STEP`, default 4: position change per frame in digital mode. Legal range 1..64.

**Ports**

- `clk_sys` in 1: system clock (7.159 MHz); all inputs are synchronous to it.
- `reset` in 1: asynchronous, active-high reset.
- `hsync` in 1: horizontal sync, active-high.
- `vsync` in 1: vertical sync, active-high.
- `vpos_in` in 8: analog/paddle position, 0 = top.
- `dig_up`, `dig_dn`, `dig_sel` in 1 each: digital control. Present only with `PADDLE_DIGITAL_EN`.
- `pad_q` out 1: one-shot output, high while timing.
- `pad_done` out 1: single-cycle pulse when `pad_q` falls, or when a zero-width window completes.
- `vpos_lat` out 8: position latched for the current frame.

## Operation

- **Edge detection.** `hs_prev` and `vs_prev` hold the inputs from the previous cycle.
  - `hs_rise = hsync & ~hs_prev`
  - `vs_rise = vsync & ~vs_prev`
  - An edge is acted on at the same clock edge on which it is detected.
- **FSM states.** IDLE, WAIT, TIMING, DONE. Line counter `cnt` is 9 bits.
- **`vs_rise` in any state** restarts the frame (it has priority over `hs_rise`):
  - Latch the position into `vpos_lat` and set `cnt` to 0.
  - If `LINE_OFFSET` = 0, go to TIMING; otherwise go to WAIT. `pad_q` is 0 on entering WAIT.
  - If the restart goes to TIMING and the latched value is 0, go to DONE instead.
  - A coincident `hs_rise` is not counted.
- **WAIT.** On `hs_rise`, `cnt` increments.
  - When `cnt+1 == LINE_OFFSET`: set `cnt` to 0 and go to TIMING, setting `pad_q` to 1.
  - If `vpos_lat` = 0 at that point, go to DONE instead and leave `pad_q` at 0.
- **TIMING.** `pad_q` is 1. On `hs_rise`, `cnt` increments.
  - When `cnt+1 == vpos_lat`: go to DONE and set `pad_q` to 0.
  - `pad_q` therefore stays high for exactly `vpos_lat` hsync periods.
- **DONE.** `pad_done` is 1 for this one cycle, then the FSM goes to IDLE.
- **IDLE.** Holds until `vs_rise`; `hs_rise` is ignored.
- **Reset** (asserted at any time, including mid-pulse):
  - state IDLE; `pad_q`, `pad_done`, `cnt`, `hs_prev`, `vs_prev` all 0; `vpos_lat` = 0x80.
  - The first frame after reset starts at the first `vs_rise`.

## Timing

- `pad_q` and `pad_done` are registered.
- `pad_q` rises 1 clock after the `hs_rise` that completes the offset, or after `vs_rise` when the offset is 0. It falls 1 clock after the terminating `hs_rise`.
- `pad_done` asserts on the same clock edge at which `pad_q` falls, and lasts 1 cycle.
- `vpos_lat` updates 1 clock after `vs_rise` and is stable for the rest of the frame.
- `vpos_in` changes mid-frame have no effect until the next `vs_rise`.
- A frame restart that aborts an active pulse drops `pad_q` to 0 without asserting `pad_done`.

## Configuration

- **`PADDLE_DIGITAL_EN` defined:**
  - The `dig_*` ports and the digital position register `pos_dig` (reset 0x80) are present.
  - On each `vs_rise`, `pos_dig` is updated:
    - `dig_up & ~dig_dn`: subtract `DIG_STEP`, saturating at 0.
    - `dig_dn & ~dig_up`: add `DIG_STEP`, saturating at 255.
    - Both or neither: hold.
  - If `dig_sel` = 1, `vpos_lat` latches the updated `pos_dig`. If `dig_sel` = 0, it latches `vpos_in`.
- **`PADDLE_DIGITAL_EN` undefined:** the `dig_*` ports and `pos_dig` do not exist, and `vpos_lat` always latches `vpos_in`.

## Structure

- **Package `pong_pkg`:**
  - `pad_state_t` enum (IDLE, WAIT, TIMING, DONE).
  - `PAD_RESET_POS` = 8'h80.
  - `PAD_CNT_W` = 9.
- **Sub-module `pad_pos_integrator`:** holds `pos_dig` and the saturating step logic. It is instantiated only under `PADDLE_DIGITAL_EN`.

## Test plan

- **Nominal frame.** `LINE_OFFSET`=16, `vpos_in`=40, 300 hsync rises after a vsync rise.
  - `pad_q` rises after the 16th `hs_rise`, is high for exactly 40 hsync periods, with one `pad_done` pulse.
  - `vpos_lat`=40.
- **Zero width.** `vpos_in`=0.
  - `pad_q` never rises.
  - `pad_done` pulses once, 1 clock after the 16th `hs_rise`.
- **Coincident edges and restart.**
  - With `hsync` and `vsync` rising in the same cycle, the line is not counted: 16 further `hs_rise` are needed before `pad_q` rises.
  - A second `vs_rise` at line 20 of TIMING drops `pad_q` to 0, gives no `pad_done`, and relatches the position.
- **Reset mid-pulse.** Assert `reset` at line 10 of TIMING.
  - `pad_q`=0 immediately and `vpos_lat`=0x80.
  - Before the next `vs_rise`, no pulse occurs despite 100 `hs_rise`.
- **Digital mode.** With `PADDLE_DIGITAL_EN`, `DIG_STEP`=4, `dig_sel`=1:
  - `dig_dn` held for 40 frames gives `vpos_lat` = 0x84, 0x88 … saturating at 0xFF.
  - `dig_up` held for 70 frames saturates at 0x00.
  - Both held gives no change.
- **Offset 0.** `LINE_OFFSET`=0, `vpos_in`=255.
  - `pad_q` rises 1 clock after `vs_rise` and is high for exactly 255 hsync periods.
